wam_dsc: RTL and testbench
==========================

Name: wam_dsc

Overview:
- Display scheduler for the whack-a-mole 4-digit tube path.
- Sits between game logic (score, hardness, start/over events) and the tube multiplexer.
- Decides each cycle which content the tubes show: lamp test, banner, countdown, live game, or game-over blink.
- Drives the multiplexer's score/hardness/flash inputs and tells game logic when play is live.

Parameters:
- LAMP_T, 95: cycles the post-reset lamp test (8888) is shown.
- CNT_T, 190: cycles each countdown digit (3, 2, 1) is shown.
- BLINK_T, 48: cycles per half-period of the game-over blink.
- OVER_N, 6: number of game-over blink half-periods before a steady hold. Must be even.
- All parameters: 1..255. Timer is 8 bits wide.

Ports:
- clk_19  input  1   slow system tick clock; all state changes on its rising edge.
- rst_n  input  1   asynchronous active-low reset.
- start  input  1   one-cycle start request.
- over  input  1   one-cycle game-end request.
- score  input  12  live 3-digit BCD score; [3:0] is the rightmost digit.
- hrdn  input  4   live hardness digit.
- lstn  input  1   live hardness-digit flash enable.
- dscore  output  12  three rightmost tube nibbles.
- dhrdn  output  4   leftmost tube nibble.
- dlstn  output  1   leftmost tube enable.
- go  output  1   one-cycle pulse on entry to PLAY.
- run  output  1   high while in PLAY.

Behaviour:
- Nibble codes follow the tube decoder: 0-9 digits, A=H, F=blank.
- Outputs are combinational decode of the registered state, timer and phase. They change on the same edge as the state.
- Reset (async, rst_n low): state BOOT, timer 0, phase 0, frozen registers 0. Outputs while in reset: dscore=888, dhrdn=8, dlstn=1, go=0, run=0.
- Reset asserted mid-operation aborts everything and returns to BOOT.
- BOOT:
  - Shows 8,888; dlstn=1.
  - Held exactly LAMP_T cycles after reset release, then IDLE.
  - start/over ignored.
- IDLE:
  - Shows banner: dhrdn=A, dscore={1,F,F}, i.e. "HI  "; dlstn=1.
  - start sampled high: CNTDN next cycle, timer cleared.
  - over ignored.
- CNTDN:
  - dhrdn=F, dscore={F,F,d}; d=3, then 2, then 1, each for exactly CNT_T cycles.
  - Total duration is 3*CNT_T cycles, then PLAY.
  - start/over ignored.
- PLAY:
  - dscore=score, dhrdn=hrdn, dlstn=lstn (pass-through, no latency); run=1.
  - go=1 on the first PLAY cycle only.
  - over sampled high: capture score/hrdn into frozen registers on that edge; OVER next cycle with timer and phase cleared.
  - start ignored. If start and over arrive together, over wins.
- OVER:
  - Even phase shows frozen score/hardness; odd phase shows all F.
  - Phase toggles every BLINK_T cycles, for OVER_N half-periods.
  - After that, frozen values are shown steadily and the timer stops; dlstn=1 throughout.
  - start at any point in OVER (blinking or steady): CNTDN next cycle. over ignored.
- run=0 and go=0 in every state other than PLAY.
- Timer and phase never wrap: they saturate or clear on each state transition.

Test Plan (bench overrides LAMP_T=4, CNT_T=5, BLINK_T=3, OVER_N=4):
- Reset release, no stimulus -> 8888 for exactly 4 cycles, then banner A,1,F,F held indefinitely; go=0, run=0.
- start pulse in IDLE at cycle k -> d0 shows 3 on cycles k+1..k+5, 2 on k+6..k+10, 1 on k+11..k+15; go=1 at k+16 only; run=1 from k+16.
- In PLAY, score=0x123, hrdn=2, lstn toggling -> dscore=0x123, dhrdn=2, dlstn tracks lstn the same cycle; a start pulse causes no state change.
- over with score=0x457 in the same cycle that score changes to 0x458 on the next edge -> OVER shows 0x457. Pattern: shown 3 cycles, blank 3, shown 3, blank 3, then steady 0x457; run=0.
- start and over in the same PLAY cycle -> OVER entered. Then start during the blank phase -> CNTDN next cycle with d0=3.
- rst_n pulsed low mid-CNTDN -> outputs immediately 8,888 with go=0 and run=0. After release, 4 lamp-test cycles, then banner.

Source files
------------

// File: rtl/wam_dsc.sv
// Display scheduler for the whack-a-mole tube path: lamp test, banner, countdown,
// live play pass-through and game-over blink, decoded from registered state/timer/phase.
module wam_dsc #(
  parameter int LAMP_T  = 95,
  parameter int CNT_T   = 190,
  parameter int BLINK_T = 48,
  parameter int OVER_N  = 6
) (
  input  logic        clk_19,
  input  logic        rst_n,
  input  logic        start,
  input  logic        over,
  input  logic [11:0] score,
  input  logic [3:0]  hrdn,
  input  logic        lstn,
  output logic [11:0] dscore,
  output logic [3:0]  dhrdn,
  output logic        dlstn,
  output logic        go,
  output logic        run
);

  typedef enum logic [2:0] {BOOT, IDLE, CNTDN, PLAY, OVER} st_t;

  localparam logic [7:0] LAMP_M  = 8'(LAMP_T - 1);
  localparam logic [7:0] CNT_M   = 8'(CNT_T - 1);
  localparam logic [7:0] BLINK_M = 8'(BLINK_T - 1);
  localparam logic [7:0] OVER_M  = 8'(OVER_N);

  st_t         st_q, st_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [7:0]  ph_q, ph_d;
  logic [11:0] fsc_q, fsc_d;
  logic [3:0]  fhr_q, fhr_d;

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    ph_d  = ph_q;
    fsc_d = fsc_q;
    fhr_d = fhr_q;
    case (st_q)
      BOOT: begin
        if (tmr_q == LAMP_M) begin
          st_d  = IDLE;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      IDLE: begin
        if (start) begin
          st_d  = CNTDN;
          tmr_d = '0;
          ph_d  = '0;
        end
      end
      CNTDN: begin
        // phase indexes the countdown digit: 0 -> "3", 1 -> "2", 2 -> "1"
        if (tmr_q == CNT_M) begin
          tmr_d = '0;
          if (ph_q == 8'd2) begin
            st_d = PLAY;
            ph_d = '0;
          end else begin
            ph_d = ph_q + 8'd1;
          end
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      PLAY: begin
        if (over) begin
          st_d  = OVER;
          tmr_d = '0;
          ph_d  = '0;
          fsc_d = score;
          fhr_d = hrdn;
        end else if (tmr_q != 8'hff) begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      OVER: begin
        if (start) begin
          st_d  = CNTDN;
          tmr_d = '0;
          ph_d  = '0;
        end else if (ph_q != OVER_M) begin
          if (tmr_q == BLINK_M) begin
            tmr_d = '0;
            ph_d  = ph_q + 8'd1;
          end else begin
            tmr_d = tmr_q + 8'd1;
          end
        end
      end
      default: st_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_19 or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= BOOT;
      tmr_q <= '0;
      ph_q  <= '0;
      fsc_q <= '0;
      fhr_q <= '0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
      ph_q  <= ph_d;
      fsc_q <= fsc_d;
      fhr_q <= fhr_d;
    end
  end

  always_comb begin
    dscore = 12'h888;
    dhrdn  = 4'h8;
    dlstn  = 1'b1;
    go     = 1'b0;
    run    = 1'b0;
    case (st_q)
      IDLE: begin
        dscore = 12'h1ff;
        dhrdn  = 4'ha;
      end
      CNTDN: begin
        dscore = {8'hff, 4'd3 - ph_q[3:0]};
        dhrdn  = 4'hf;
      end
      PLAY: begin
        dscore = score;
        dhrdn  = hrdn;
        dlstn  = lstn;
        run    = 1'b1;
        // timer saturates in PLAY, so zero marks only the entry cycle
        go     = (tmr_q == 8'd0);
      end
      OVER: begin
        if (ph_q[0]) begin
          dscore = 12'hfff;
          dhrdn  = 4'hf;
        end else begin
          dscore = fsc_q;
          dhrdn  = fhr_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wam_dsc.sv
// Scoreboard bench for wam_dsc: a cycle-count reference model pushes the expected
// display per cycle; a negedge monitor pops and compares.
module tb_wam_dsc;
  localparam int LT = 4;
  localparam int CT = 5;
  localparam int BT = 3;
  localparam int ON = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        over = 1'b0;
  logic [11:0] score = '0;
  logic [3:0]  hrdn = '0;
  logic        lstn = 1'b0;
  logic [11:0] dscore;
  logic [3:0]  dhrdn;
  logic        dlstn, go, run;

  wam_dsc #(.LAMP_T(LT), .CNT_T(CT), .BLINK_T(BT), .OVER_N(ON)) dut (
    .clk_19(clk), .rst_n(rst_n), .start(start), .over(over), .score(score),
    .hrdn(hrdn), .lstn(lstn), .dscore(dscore), .dhrdn(dhrdn), .dlstn(dlstn),
    .go(go), .run(run)
  );

  always #5 clk = ~clk;

  typedef enum {M_BOOT, M_IDLE, M_CNT, M_PLAY, M_OVER} mode_t;
  mode_t       mode = M_BOOT;
  int          n = 0;          // cycles spent in the current mode
  logic [11:0] fsc = '0;
  logic [3:0]  fhr = '0;
  logic [18:0] expq[$];
  int          checks = 0;
  int          failures = 0;

  // expected {dscore, dhrdn, dlstn, go, run} for the current cycle
  function automatic logic [18:0] expect_now();
    logic [11:0] s;
    if (!rst_n) return {12'h888, 4'h8, 3'b100};
    case (mode)
      M_BOOT: return {12'h888, 4'h8, 3'b100};
      M_IDLE: return {12'h1ff, 4'ha, 3'b100};
      M_CNT: begin
        s = 12'hff0 | 12'(3 - n / CT);
        return {s, 4'hf, 3'b100};
      end
      M_PLAY: return {score, hrdn, lstn, (n == 0), 1'b1};
      default: begin
        if (n < ON * BT && ((n / BT) % 2) == 1) return {12'hfff, 4'hf, 3'b100};
        return {fsc, fhr, 3'b100};
      end
    endcase
  endfunction

  task automatic step(input logic s, input logic o);
    if (!rst_n) begin
      mode = M_BOOT; n = 0;
    end else begin
      case (mode)
        M_BOOT: begin n++; if (n == LT) begin mode = M_IDLE; n = 0; end end
        M_IDLE: if (s) begin mode = M_CNT; n = 0; end
        M_CNT:  begin n++; if (n == 3 * CT) begin mode = M_PLAY; n = 0; end end
        M_PLAY: begin
          if (o) begin fsc = score; fhr = hrdn; mode = M_OVER; n = 0; end
          else n++;
        end
        default: begin
          if (s) begin mode = M_CNT; n = 0; end
          else n++;
        end
      endcase
    end
  endtask

  task automatic cyc(input logic s, input logic o, input logic [11:0] sc,
                     input logic [3:0] hr, input logic l);
    start = s; over = o; score = sc; hrdn = hr; lstn = l;
    expq.push_back(expect_now());
    @(posedge clk);
    step(s, o);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, score, hrdn, lstn);
  endtask

  function automatic logic [11:0] rbcd();
    return {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
  endfunction

  always @(negedge clk) begin
    logic [18:0] e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {dscore, dhrdn, dlstn, go, run};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL disp t=%0t got dscore=%h dhrdn=%h dlstn=%b go=%b run=%b exp dscore=%h dhrdn=%h dlstn=%b go=%b run=%b",
                 $time, a[18:7], a[6:3], a[2], a[1], a[0], e[18:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    idle(3);
    rst_n = 1'b1;
    idle(12);
    cyc(1'b1, 1'b0, 12'h000, 4'h0, 1'b0);
    idle(15);
    for (int i = 0; i < 8; i++)
      cyc((i == 4), 1'b0, 12'h123, 4'h2, i[0]);
    cyc(1'b0, 1'b1, 12'h457, 4'h5, 1'b1);
    cyc(1'b0, 1'b0, 12'h458, 4'h6, 1'b0);
    idle(16);
    cyc(1'b1, 1'b0, score, hrdn, lstn);
    idle(17);
    cyc(1'b1, 1'b1, 12'h999, 4'h9, 1'b1);
    idle(4);
    cyc(1'b1, 1'b0, score, hrdn, lstn);
    idle(7);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(8);
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(7) == 0), ($urandom_range(9) == 0), rbcd(),
          4'($urandom_range(9)), 1'($urandom_range(1)));
    idle(1);
    @(negedge clk); #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp pending=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
